maze_renderer: RTL

MAZE_RENDERER -- requirements
Module: maze_renderer

---
 rtl/maze_pkg.sv | 28 ++
 rtl/maze_pixel_classify.sv | 78 +++++++
 rtl/maze_renderer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the maze renderer: move directions, FSM states,
// RGB565 colour constants and a saturating counter helper.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_COMMIT = 2'b10,
    ST_WIN    = 2'b11
  } state_e;

  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLACK = 16'h0000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/maze_pixel_classify.sv
// Combinational pixel classifier: maps a linear pixel address to its colour
// from the wall maps and the current player cell.
module maze_pixel_classify
  import maze_pkg::*;
#(
  parameter int          DISP_W     = 96,
  parameter int          DISP_H     = 64,
  parameter int          COLS       = 7,
  parameter int          ROWS       = 5,
  parameter int          CELL_PX    = 12,
  parameter int          WALL_PX    = 3,
  parameter int          EXIT_COL   = 6,
  parameter int          EXIT_ROW   = 4,
  parameter int          COL_W      = 3,
  parameter int          ROW_W      = 3,
  parameter logic [15:0] WALL_RGB   = RGB_WHITE,
  parameter logic [15:0] PLAYER_RGB = RGB_BLUE,
  parameter logic [15:0] EXIT_RGB   = RGB_GREEN,
  parameter logic [15:0] BG_RGB     = RGB_BLACK
) (
  input  logic [12:0]                index,
  input  logic [COLS*(ROWS+1)-1:0]   h_walls,
  input  logic [(COLS+1)*ROWS-1:0]   v_walls,
  input  logic [COL_W-1:0]           player_col,
  input  logic [ROW_W-1:0]           player_row,
  output logic [15:0]                colour
);

  localparam int H_BITS = COLS * (ROWS + 1);
  localparam int V_BITS = (COLS + 1) * ROWS;

  logic [12:0] x_pos, y_pos;
  logic [12:0] cell_x, cell_y;
  logic [12:0] off_x, off_y;
  logic [12:0] h_sel, v_sel;
  logic        in_maze, in_x_band, in_y_band;
  logic        h_bit, v_bit;
  logic        is_player, is_exit;

  always_comb begin
    x_pos  = index % 13'(DISP_W);
    y_pos  = index / 13'(DISP_W);
    cell_x = x_pos / 13'(CELL_PX);
    cell_y = y_pos / 13'(CELL_PX);
    off_x  = x_pos % 13'(CELL_PX);
    off_y  = y_pos % 13'(CELL_PX);

    in_maze = (index < 13'(DISP_W * DISP_H))
           && (x_pos < 13'(COLS * CELL_PX + WALL_PX))
           && (y_pos < 13'(ROWS * CELL_PX + WALL_PX));
    in_x_band = off_x < 13'(WALL_PX);
    in_y_band = off_y < 13'(WALL_PX);

    // A band's line index is the cell coordinate on its own axis; the other
    // coordinate picks the cell the band borders.
    h_sel = cell_y * 13'(COLS) + cell_x;
    v_sel = cell_y * 13'(COLS + 1) + cell_x;
    h_bit = |(h_walls & (H_BITS'(1) << h_sel));
    v_bit = |(v_walls & (V_BITS'(1) << v_sel));

    is_player = (cell_x == 13'(player_col)) && (cell_y == 13'(player_row));
    is_exit   = (cell_x == 13'(EXIT_COL)) && (cell_y == 13'(EXIT_ROW));
  end

  // NOTE: the default is assigned before any branch so every path drives
  // colour and no latch is inferred.
  always_comb begin
    colour = BG_RGB;
    if (in_maze) begin
      if (in_x_band && in_y_band) colour = WALL_RGB;
      else if (in_x_band)         colour = v_bit ? WALL_RGB : BG_RGB;
      else if (in_y_band)         colour = h_bit ? WALL_RGB : BG_RGB;
      else if (is_player)         colour = PLAYER_RGB;
      else if (is_exit)           colour = EXIT_RGB;
    end
  end

endmodule

// File: rtl/maze_renderer.sv
// Maze game core: move-handling FSM over a wall map plus a registered
// pixel lookup for the display scan.
module maze_renderer
  import maze_pkg::*;
#(
  parameter int          DISP_W     = 96,
  parameter int          DISP_H     = 64,
  parameter int          COLS       = 7,
  parameter int          ROWS       = 5,
  parameter int          CELL_PX    = 12,
  parameter int          WALL_PX    = 3,
  parameter int          START_COL  = 0,
  parameter int          START_ROW  = 0,
  parameter int          EXIT_COL   = 6,
  parameter int          EXIT_ROW   = 4,
  parameter logic [15:0] WALL_RGB   = RGB_WHITE,
  parameter logic [15:0] PLAYER_RGB = RGB_BLUE,
  parameter logic [15:0] EXIT_RGB   = RGB_GREEN,
  parameter logic [15:0] BG_RGB     = RGB_BLACK,
  localparam int         COL_W      = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int         ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [12:0]               index,
  output logic [15:0]               data,
  input  logic [COLS*(ROWS+1)-1:0]  h_walls,
  input  logic [(COLS+1)*ROWS-1:0]  v_walls,
  input  logic                      move_valid,
  input  logic [1:0]                move_dir,
  output logic                      move_ready,
  input  logic                      restart,
  output logic                      move_done,
  output logic                      move_ok,
  output logic [COL_W-1:0]          player_col,
  output logic [ROW_W-1:0]          player_row,
  output logic                      win,
  output logic [7:0]                move_count
);

  localparam int H_BITS = COLS * (ROWS + 1);
  localparam int V_BITS = (COLS + 1) * ROWS;

  state_e           state_q, state_d;
  dir_e             dir_q;
  logic [COL_W-1:0] col_q, target_col;
  logic [ROW_W-1:0] row_q, target_row;
  logic [7:0]       count_q;
  logic             win_q, done_q, ok_q;
  logic             accept, blocked, at_exit;
  logic [31:0]      h_sel, v_sel;
  logic [15:0]      pixel_colour;

  maze_pixel_classify #(
    .DISP_W(DISP_W), .DISP_H(DISP_H), .COLS(COLS), .ROWS(ROWS),
    .CELL_PX(CELL_PX), .WALL_PX(WALL_PX),
    .EXIT_COL(EXIT_COL), .EXIT_ROW(EXIT_ROW),
    .COL_W(COL_W), .ROW_W(ROW_W),
    .WALL_RGB(WALL_RGB), .PLAYER_RGB(PLAYER_RGB),
    .EXIT_RGB(EXIT_RGB), .BG_RGB(BG_RGB)
  ) u_classify (
    .index      (index),
    .h_walls    (h_walls),
    .v_walls    (v_walls),
    .player_col (col_q),
    .player_row (row_q),
    .colour     (pixel_colour)
  );

  assign at_exit = (col_q == COL_W'(EXIT_COL)) && (row_q == ROW_W'(EXIT_ROW));

  // Wall crossed by the latched move; an open border still cannot carry the
  // player outside the representable grid.
  always_comb begin
    blocked    = 1'b0;
    target_col = col_q;
    target_row = row_q;
    h_sel      = 32'(row_q) * COLS + 32'(col_q);
    v_sel      = 32'(row_q) * (COLS + 1) + 32'(col_q);
    unique case (dir_q)
      DIR_UP: begin
        blocked    = |(h_walls & (H_BITS'(1) << h_sel)) || (row_q == '0);
        target_row = row_q - ROW_W'(1);
      end
      DIR_DOWN: begin
        blocked    = |(h_walls & (H_BITS'(1) << (h_sel + COLS)))
                  || (row_q == ROW_W'(ROWS - 1));
        target_row = row_q + ROW_W'(1);
      end
      DIR_LEFT: begin
        blocked    = |(v_walls & (V_BITS'(1) << v_sel)) || (col_q == '0);
        target_col = col_q - COL_W'(1);
      end
      DIR_RIGHT: begin
        blocked    = |(v_walls & (V_BITS'(1) << (v_sel + 1)))
                  || (col_q == COL_W'(COLS - 1));
        target_col = col_q + COL_W'(1);
      end
      default: blocked = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (move_valid) begin
          state_d = ST_CHECK;
          accept  = 1'b1;
        end
      end
      ST_CHECK:  state_d = ST_COMMIT;
      ST_COMMIT: state_d = at_exit ? ST_WIN : ST_IDLE;
      ST_WIN:    state_d = ST_WIN;
      default:   state_d = ST_IDLE;
    endcase
    if (restart) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      col_q   <= COL_W'(START_COL);
      row_q   <= ROW_W'(START_ROW);
      count_q <= 8'd0;
      win_q   <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      data    <= 16'h0000;
    end else begin
      state_q <= state_d;
      data    <= pixel_colour;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      if (accept) dir_q <= dir_e'(move_dir);
      if (restart) begin
        col_q   <= COL_W'(START_COL);
        row_q   <= ROW_W'(START_ROW);
        count_q <= 8'd0;
        win_q   <= 1'b0;
      end else if (state_q == ST_CHECK) begin
        // Result is registered so the pulse, new position and count all
        // appear together in the COMMIT cycle.
        done_q <= 1'b1;
        ok_q   <= !blocked;
        if (!blocked) begin
          col_q   <= target_col;
          row_q   <= target_row;
          count_q <= sat_inc8(count_q);
        end
      end else if (state_q == ST_COMMIT && at_exit) begin
        win_q <= 1'b1;
      end
    end
  end

  assign move_ready = (state_q == ST_IDLE);
  assign move_done  = done_q;
  assign move_ok    = ok_q;
  assign player_col = col_q;
  assign player_row = row_q;
  assign win        = win_q;
  assign move_count = count_q;

endmodule
